// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // Fetch controller states.
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    // addi x0, x0, 0 -- what the decoder sees in IF/ID before the first fetch.
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    // Every instruction is one 32-bit word.
    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus and IF/ID pipeline register bundle.
// The fetch stage is the master; memory and decoder together form the slave side.
interface fetch_if #(
    parameter int ADDRESS_SIZE     = 32,
    parameter int INSTRUCTION_SIZE = 32
);
    logic [ADDRESS_SIZE-1:0]     imem_address;
    logic [INSTRUCTION_SIZE-1:0] imem_instruction;
    logic                        ifid_valid;
    logic [ADDRESS_SIZE-1:0]     ifid_pc;
    logic [INSTRUCTION_SIZE-1:0] ifid_instruction;

    modport master (
        output imem_address,
        input  imem_instruction,
        output ifid_valid,
        output ifid_pc,
        output ifid_instruction
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        input  ifid_valid,
        input  ifid_pc,
        input  ifid_instruction
    );
endinterface

// File: rtl/program_counter.sv
// Program counter register: word-aligned load, sequential increment, or hold.
// Load takes priority over increment; the low two address bits are always zero.
module program_counter
    import fetch_pkg::*;
#(
    parameter int                    ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC   = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [ADDRESS_SIZE-1:2] load_target,
    input  logic                    increment,
    output logic [ADDRESS_SIZE-1:0] pc
);

    // PC update: redirect load, next sequential word (wrapping), or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= {load_target, 2'b00};
        end else if (increment) begin
            pc <= pc + ADDRESS_SIZE'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction
// memory and registers the word into IF/ID. Handles stall, redirect (flush),
// halt/resume, a sticky misaligned-target flag and a delivered-instruction count.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                      ADDRESS_SIZE     = 32,
    parameter int                      INSTRUCTION_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC         = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    input  logic                    halt,
    input  logic                    resume,
    output logic                    halted,
    output logic                    misalign_err,
    output logic [31:0]             fetch_count,
    fetch_if.master                 bus
);

    state_t                  state;
    state_t                  next_state;
    logic [ADDRESS_SIZE-1:0] pc;

    logic pc_load;
    logic pc_increment;
    logic capture;
    logic flush;
    logic misalign_set;

    program_counter #(
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .RESET_PC     (RESET_PC)
    ) u_program_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (pc_load),
        .load_target (redirect_pc[ADDRESS_SIZE-1:2]),
        .increment   (pc_increment),
        .pc          (pc)
    );

    assign bus.imem_address = pc;
    assign halted           = (state == HALTED);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next state: redirect keeps RUN busy, resume beats halt while halted.
    always_comb begin
        next_state = state;
        unique case (state)
            BOOT:    next_state = RUN;
            RUN:     if (!redirect_valid && halt) next_state = HALTED;
            HALTED:  if (resume) next_state = RUN;
            default: next_state = BOOT;
        endcase
    end

    // Datapath controls in priority order: redirect, halt, stall, fetch.
    always_comb begin
        pc_load      = 1'b0;
        pc_increment = 1'b0;
        capture      = 1'b0;
        flush        = 1'b0;
        misalign_set = 1'b0;
        unique case (state)
            RUN: begin
                if (redirect_valid) begin
                    pc_load      = 1'b1;
                    flush        = 1'b1;
                    misalign_set = (redirect_pc[1:0] != 2'b00);
                end else if (halt) begin
                    flush = 1'b1;
                end else if (!stall) begin
                    capture      = 1'b1;
                    pc_increment = 1'b1;
                end
            end
            HALTED: begin
                flush = 1'b1;
                if (redirect_valid) begin
                    pc_load      = 1'b1;
                    misalign_set = (redirect_pc[1:0] != 2'b00);
                end
            end
            default: ;
        endcase
    end

    // IF/ID pipeline register: flush clears valid, capture takes the memory word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ifid_valid       <= 1'b0;
            bus.ifid_pc          <= '0;
            bus.ifid_instruction <= INSTRUCTION_SIZE'(NOP_INSTRUCTION);
        end else if (flush) begin
            bus.ifid_valid <= 1'b0;
        end else if (capture) begin
            bus.ifid_valid       <= 1'b1;
            bus.ifid_pc          <= pc;
            bus.ifid_instruction <= bus.imem_instruction;
        end
    end

    // Delivered-instruction counter (wraps) and sticky misaligned-redirect flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count  <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (capture) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (misalign_set) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a 16-word combinational memory model.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        resume;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [16];

    int total  = 0;
    int passed = 0;

    fetch_if #(.ADDRESS_SIZE(32), .INSTRUCTION_SIZE(32)) bus ();

    fetch_stage #(
        .ADDRESS_SIZE     (32),
        .INSTRUCTION_SIZE (32),
        .RESET_PC         (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .resume         (resume),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory: word index is address bits [5:2].
    assign bus.imem_instruction = mem[bus.imem_address[5:2]];

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [64:0] ifid;
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if (ifid !== {1'b0, 32'h0, 32'h0000_0013})
            $display("[TB] FAIL reset_ifid: got %h expected %h", ifid, {1'b0, 32'h0, 32'h0000_0013});
        else passed++;
        total++;
        if ({bus.imem_address, fetch_count, halted, misalign_err} !== {32'h0, 32'h0, 1'b0, 1'b0})
            $display("[TB] FAIL reset_state: got pc=%h cnt=%0d halted=%b mis=%b expected 0/0/0/0",
                     bus.imem_address, fetch_count, halted, misalign_err);
        else passed++;
    endtask

    task automatic test_boot_fetch();
        logic [64:0] ifid;
        tick();
        total++;
        if ({bus.ifid_valid, bus.imem_address} !== {1'b0, 32'h0})
            $display("[TB] FAIL boot_no_fetch: got valid=%b pc=%h expected 0/00000000", bus.ifid_valid, bus.imem_address);
        else passed++;
        tick();
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if (ifid !== {1'b1, 32'h0, 32'hffff_ffff})
            $display("[TB] FAIL fetch0: got %h expected %h", ifid, {1'b1, 32'h0, 32'hffff_ffff});
        else passed++;
        tick();
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if (ifid !== {1'b1, 32'h4, 32'h0010_0093})
            $display("[TB] FAIL fetch4: got %h expected %h", ifid, {1'b1, 32'h4, 32'h0010_0093});
        else passed++;
        total++;
        if ({bus.imem_address, fetch_count} !== {32'h8, 32'd2})
            $display("[TB] FAIL fetch_pc_count: got pc=%h cnt=%0d expected 00000008/2", bus.imem_address, fetch_count);
        else passed++;
    endtask

    task automatic test_stall();
        logic [64:0] ifid;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
            total++;
            if ({ifid, bus.imem_address, fetch_count} !== {1'b1, 32'h4, 32'h0010_0093, 32'h8, 32'd2})
                $display("[TB] FAIL stall_hold%0d: got ifid=%h pc=%h cnt=%0d expected ifid=%h pc=00000008 cnt=2",
                         i, ifid, bus.imem_address, fetch_count, {1'b1, 32'h4, 32'h0010_0093});
            else passed++;
        end
        stall = 1'b0;
        tick();
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if ({ifid, fetch_count} !== {1'b1, 32'h8, 32'h0020_0113, 32'd3})
            $display("[TB] FAIL stall_release: got ifid=%h cnt=%0d expected %h cnt=3",
                     ifid, fetch_count, {1'b1, 32'h8, 32'h0020_0113});
        else passed++;
    endtask

    task automatic test_redirect();
        logic [64:0] ifid;
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        tick();
        total++;
        if ({bus.ifid_valid, bus.imem_address, misalign_err, fetch_count} !== {1'b0, 32'h14, 1'b0, 32'd3})
            $display("[TB] FAIL redirect_bubble: got valid=%b pc=%h mis=%b cnt=%0d expected 0/00000014/0/3",
                     bus.ifid_valid, bus.imem_address, misalign_err, fetch_count);
        else passed++;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if ({ifid, fetch_count} !== {1'b1, 32'h14, 32'ha000_0005, 32'd4})
            $display("[TB] FAIL redirect_target: got ifid=%h cnt=%0d expected %h cnt=4",
                     ifid, fetch_count, {1'b1, 32'h14, 32'ha000_0005});
        else passed++;
    endtask

    task automatic test_misalign();
        logic [64:0] ifid;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h17;
        tick();
        total++;
        if ({bus.ifid_valid, bus.imem_address, misalign_err} !== {1'b0, 32'h14, 1'b1})
            $display("[TB] FAIL misalign_load: got valid=%b pc=%h mis=%b expected 0/00000014/1",
                     bus.ifid_valid, bus.imem_address, misalign_err);
        else passed++;
        redirect_valid = 1'b0;
        tick();
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if ({ifid, fetch_count} !== {1'b1, 32'h14, 32'ha000_0005, 32'd5})
            $display("[TB] FAIL misalign_fetch: got ifid=%h cnt=%0d expected %h cnt=5",
                     ifid, fetch_count, {1'b1, 32'h14, 32'ha000_0005});
        else passed++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0c;
        tick();
        redirect_valid = 1'b0;
        total++;
        if ({bus.imem_address, misalign_err} !== {32'h0c, 1'b1})
            $display("[TB] FAIL misalign_sticky: got pc=%h mis=%b expected 0000000c/1", bus.imem_address, misalign_err);
        else passed++;
    endtask

    task automatic test_halt_resume();
        logic [64:0] ifid;
        halt = 1'b1;
        tick();
        total++;
        if ({halted, bus.ifid_valid, bus.imem_address, fetch_count} !== {1'b1, 1'b0, 32'h0c, 32'd5})
            $display("[TB] FAIL halt_enter: got halted=%b valid=%b pc=%h cnt=%0d expected 1/0/0000000c/5",
                     halted, bus.ifid_valid, bus.imem_address, fetch_count);
        else passed++;
        tick();
        total++;
        if ({halted, bus.imem_address} !== {1'b1, 32'h0c})
            $display("[TB] FAIL halt_hold: got halted=%b pc=%h expected 1/0000000c", halted, bus.imem_address);
        else passed++;
        resume = 1'b1;
        tick();
        halt   = 1'b0;
        resume = 1'b0;
        total++;
        if ({halted, bus.ifid_valid, bus.imem_address} !== {1'b0, 1'b0, 32'h0c})
            $display("[TB] FAIL resume_wins: got halted=%b valid=%b pc=%h expected 0/0/0000000c",
                     halted, bus.ifid_valid, bus.imem_address);
        else passed++;
        tick();
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if ({ifid, fetch_count} !== {1'b1, 32'h0c, 32'ha000_0003, 32'd6})
            $display("[TB] FAIL resume_fetch: got ifid=%h cnt=%0d expected %h cnt=6",
                     ifid, fetch_count, {1'b1, 32'h0c, 32'ha000_0003});
        else passed++;
    endtask

    task automatic test_wrap();
        logic [64:0] ifid;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_fffc;
        tick();
        redirect_valid = 1'b0;
        tick();
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if ({ifid, bus.imem_address, fetch_count} !== {1'b1, 32'hffff_fffc, 32'ha000_000f, 32'h0, 32'd7})
            $display("[TB] FAIL pc_wrap: got ifid=%h pc=%h cnt=%0d expected %h pc=00000000 cnt=7",
                     ifid, bus.imem_address, fetch_count, {1'b1, 32'hffff_fffc, 32'ha000_000f});
        else passed++;
    endtask

    task automatic test_halted_redirect();
        logic [64:0] ifid;
        halt = 1'b1;
        tick();
        halt           = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick();
        redirect_valid = 1'b0;
        total++;
        if ({halted, bus.ifid_valid, bus.imem_address} !== {1'b1, 1'b0, 32'h20})
            $display("[TB] FAIL halted_redirect: got halted=%b valid=%b pc=%h expected 1/0/00000020",
                     halted, bus.ifid_valid, bus.imem_address);
        else passed++;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        tick();
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if ({ifid, fetch_count} !== {1'b1, 32'h20, 32'ha000_0008, 32'd8})
            $display("[TB] FAIL halted_redirect_fetch: got ifid=%h cnt=%0d expected %h cnt=8",
                     ifid, fetch_count, {1'b1, 32'h20, 32'ha000_0008});
        else passed++;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if ({halted, ifid, fetch_count} !== {1'b0, 1'b1, 32'h24, 32'ha000_0009, 32'd9})
            $display("[TB] FAIL resume_in_run: got halted=%b ifid=%h cnt=%0d expected 0 %h cnt=9",
                     halted, ifid, fetch_count, {1'b1, 32'h24, 32'ha000_0009});
        else passed++;
    endtask

    task automatic test_async_reset();
        logic [64:0] ifid;
        #2;
        rst_n = 1'b0;
        #1;
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if ({ifid, bus.imem_address, fetch_count, halted, misalign_err} !==
            {1'b0, 32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 1'b0})
            $display("[TB] FAIL async_reset: got ifid=%h pc=%h cnt=%0d halted=%b mis=%b expected %h pc=0 cnt=0 0 0",
                     ifid, bus.imem_address, fetch_count, halted, misalign_err, {1'b0, 32'h0, 32'h0000_0013});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        ifid = {bus.ifid_valid, bus.ifid_pc, bus.ifid_instruction};
        total++;
        if ({ifid, fetch_count} !== {1'b1, 32'h0, 32'hffff_ffff, 32'd1})
            $display("[TB] FAIL reboot_fetch: got ifid=%h cnt=%0d expected %h cnt=1",
                     ifid, fetch_count, {1'b1, 32'h0, 32'hffff_ffff});
        else passed++;
    endtask

    // Test sequence.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'ha000_0000 | i;
        mem[0] = 32'hffff_ffff;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;

        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        resume         = 1'b0;

        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        test_boot_fetch();
        test_stall();
        test_redirect();
        test_misalign();
        test_halt_resume();
        test_wrap();
        test_halted_redirect();
        test_async_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
